counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter_if.sv | 15 +
 rtl/counter_arbiter.sv | 99 +++++++++
 tb/tb_counter_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// Handshake bundle between requesters and the shared step counter arbiter.
interface counter_arbiter_if #(
  parameter int CNT_W = 3,
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] req;
  logic             clr;
  logic [N_REQ-1:0] gnt;
  logic [CNT_W-1:0] count;
  logic             wrap;
  logic             busy;

  modport master (output req, clr, input gnt, count, wrap, busy);
  modport slave  (input req, clr, output gnt, count, wrap, busy);
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one step each of a shared
// counter through a 4-phase req/gnt handshake.
module counter_arbiter #(
  parameter int CNT_W = 3,
  parameter int N_REQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  counter_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [PTR_W-1:0]   pick;
  logic               found;

  // Search starts just past the last released winner, so that requester
  // drops to lowest priority on the next round.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    gnt_d   = gnt_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << pick;
          win_d   = pick;
          count_d = count_q + 1'b1;
          wrap_d  = (count_q == '1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[win_q]) begin
          gnt_d   = '0;
          ptr_d   = win_q;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear overrides any increment and suppresses the rollover pulse.
    if (bus.clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed self-checking bench for counter_arbiter: reset, handshake timing,
// round-robin order, rollover pulse and clear interactions.
module tb_counter_arbiter;
  localparam int CNT_W = 3;
  localparam int N_REQ = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  counter_arbiter_if #(.CNT_W(CNT_W), .N_REQ(N_REQ)) bus ();

  counter_arbiter #(.CNT_W(CNT_W), .N_REQ(N_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock.
  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_gnt"},   32'(bus.gnt),   32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_wrap"},  32'(bus.wrap),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    rst = 1'b0;
  endtask

  // Full handshake for one requester: grant edge, release edge, back to idle.
  task automatic do_grant(input logic [N_REQ-1:0] bits, input int exp_cnt, input logic exp_wrap);
    bus.req = bits;
    step();
    check("grant_gnt",   32'(bus.gnt),   32'(bits));
    check("grant_count", 32'(bus.count), 32'(exp_cnt));
    check("grant_wrap",  32'(bus.wrap),  32'(exp_wrap));
    check("grant_busy",  32'(bus.busy),  32'd1);
    bus.req = '0;
    step();
    check("rel_gnt",  32'(bus.gnt),  32'd0);
    check("rel_busy", 32'(bus.busy), 32'd1);
    check("rel_wrap", 32'(bus.wrap), 32'd0);
    step();
    check("idle_busy",  32'(bus.busy),  32'd0);
    check("idle_count", 32'(bus.count), 32'(exp_cnt));
  endtask

  logic [N_REQ-1:0] rr_order [4];

  initial begin
    rr_order[0] = 3'b001;
    rr_order[1] = 3'b010;
    rr_order[2] = 3'b100;
    rr_order[3] = 3'b001;

    rst     = 1'b1;
    bus.req = '0;
    bus.clr = 1'b0;
    #2;
    check("rst_gnt",   32'(bus.gnt),   32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_wrap",  32'(bus.wrap),  32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);

    // Single requester timing from reset.
    bus.req = 3'b001;
    #1 rst = 1'b0;
    step();
    check("single_e1_gnt",   32'(bus.gnt),   32'b001);
    check("single_e1_count", 32'(bus.count), 32'd1);
    check("single_e1_busy",  32'(bus.busy),  32'd1);
    step();
    check("single_e2_gnt",   32'(bus.gnt),   32'b001);
    check("single_e2_count", 32'(bus.count), 32'd1);
    bus.req = '0;
    step();
    check("single_e3_gnt",  32'(bus.gnt),  32'd0);
    check("single_e3_busy", 32'(bus.busy), 32'd1);
    step();
    check("single_e4_busy",  32'(bus.busy),  32'd0);
    check("single_e4_count", 32'(bus.count), 32'd1);

    // Round-robin with all requesters active from reset.
    bus.req = 3'b111;
    pulse_rst("rr_rst");
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_gnt",   32'(bus.gnt),   32'(rr_order[k]));
      check("rr_count", 32'(bus.count), 32'(k + 1));
      bus.req = 3'b111 & ~rr_order[k];
      step();
      check("rr_rel_gnt",  32'(bus.gnt),  32'd0);
      check("rr_rel_busy", 32'(bus.busy), 32'd1);
      bus.req = 3'b111;
      step();
      check("rr_idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.req = '0;

    // Rollover: 4 -> 7, then 7 -> 0 with a one-cycle wrap pulse.
    do_grant(3'b010, 5, 1'b0);
    do_grant(3'b100, 6, 1'b0);
    do_grant(3'b001, 7, 1'b0);
    do_grant(3'b010, 0, 1'b1);

    // Clear colliding with a grant in IDLE at count 5.
    for (int i = 1; i <= 5; i++) do_grant(3'b001, i, 1'b0);
    bus.req = 3'b100;
    bus.clr = 1'b1;
    step();
    check("clrcol_gnt",   32'(bus.gnt),   32'b100);
    check("clrcol_count", 32'(bus.count), 32'd0);
    check("clrcol_wrap",  32'(bus.wrap),  32'd0);
    check("clrcol_busy",  32'(bus.busy),  32'd1);
    bus.clr = 1'b0;
    bus.req = '0;
    step();
    step();
    check("clrcol_idle_busy", 32'(bus.busy), 32'd0);

    // Clear while GRANT is held; a second requester is ignored meanwhile.
    do_grant(3'b001, 1, 1'b0);
    do_grant(3'b001, 2, 1'b0);
    bus.req = 3'b001;
    step();
    check("clrg_pre_gnt",   32'(bus.gnt),   32'b001);
    check("clrg_pre_count", 32'(bus.count), 32'd3);
    bus.req = 3'b011;
    bus.clr = 1'b1;
    step();
    check("clrg_gnt",   32'(bus.gnt),   32'b001);
    check("clrg_count", 32'(bus.count), 32'd0);
    check("clrg_busy",  32'(bus.busy),  32'd1);
    bus.clr = 1'b0;
    step();
    check("clrg_hold_gnt",   32'(bus.gnt),   32'b001);
    check("clrg_hold_count", 32'(bus.count), 32'd0);
    bus.req = '0;
    step();
    step();
    check("clrg_idle_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a GRANT at count 4.
    do_grant(3'b001, 1, 1'b0);
    do_grant(3'b001, 2, 1'b0);
    do_grant(3'b001, 3, 1'b0);
    bus.req = 3'b010;
    step();
    check("rstg_pre_gnt",   32'(bus.gnt),   32'b010);
    check("rstg_pre_count", 32'(bus.count), 32'd4);
    pulse_rst("rstg");
    step();
    check("rstg_after_gnt",   32'(bus.gnt),   32'b010);
    check("rstg_after_count", 32'(bus.count), 32'd1);
    bus.req = '0;
    step();
    step();
    check("rstg_idle_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
